// File: rtl/spi_peripheral.sv
// SPI mode 3 (CPOL=1, CPHA=1, MSB first) responder with fixed SIZE-bit frames.
// Pins are oversampled in the clk_in domain; off-length frames raise frame_error_out.
module spi_peripheral #(
  parameter int SIZE        = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic            sclk_in,
  input  logic            cs_n_in,
  input  logic            mosi_in,
  output logic            miso_out,
  output logic            miso_oe_out,
  input  logic [SIZE-1:0] tx_data_in,
  input  logic            tx_load_in,
  output logic [SIZE-1:0] rx_data_out,
  output logic            rx_valid_out,
  output logic            frame_error_out,
  output logic            busy_out
);
  localparam int CW = $clog2(SIZE + 2);
  localparam int SW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {WAIT_IDLE = 2'd0, IDLE = 2'd1, ACTIVE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [SIZE-1:0]        tx_hold_q, tx_hold_d;
  logic [SIZE-1:0]        tx_shift_q, tx_shift_d;
  logic [SIZE-1:0]        rx_shift_q, rx_shift_d;
  logic [SIZE-1:0]        rx_data_q, rx_data_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic                   miso_q, miso_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   done_ok_q, done_ok_d;
  logic                   done_err_q, done_err_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_fall, sclk_rise, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    tx_hold_d   = tx_load_in ? tx_data_in : tx_hold_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    settle_d    = settle_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    done_ok_d   = 1'b0;
    done_err_d  = 1'b0;

    // Frame-end verdict is registered once more before it reaches the outputs.
    if (done_ok_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end
    if (done_err_q) frame_err_d = 1'b1;

    unique case (state_q)
      WAIT_IDLE: begin
        // Sync chains reset high, so wait until they carry real pin values
        // before trusting cs; otherwise a frame live at reset release would be joined.
        if (settle_q != SW'(SYNC_STAGES)) settle_d = settle_q + SW'(1);
        else if (cs_s)                    state_d  = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          tx_shift_d = tx_hold_q;
          miso_d     = tx_hold_q[SIZE-1];
          bit_cnt_d  = '0;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          if (bit_cnt_q == CW'(SIZE)) done_ok_d  = 1'b1;
          else                        done_err_d = 1'b1;
          state_d = IDLE;
        end else if (sclk_fall) begin
          miso_d     = tx_shift_q[SIZE-1];
          tx_shift_d = {tx_shift_q[SIZE-2:0], 1'b0};
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[SIZE-2:0], mosi_s};
          if (bit_cnt_q != CW'(SIZE + 1)) bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= WAIT_IDLE;
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
      tx_hold_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      settle_q    <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      done_ok_q   <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      tx_hold_q   <= tx_hold_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      settle_q    <= settle_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      done_ok_q   <= done_ok_d;
      done_err_q  <= done_err_d;
    end
  end

  assign miso_out        = miso_q;
  assign miso_oe_out     = ~cs_s & (state_q == ACTIVE);
  assign busy_out        = (state_q == ACTIVE);
  assign rx_data_out     = rx_data_q;
  assign rx_valid_out    = rx_valid_q;
  assign frame_error_out = frame_err_q;
endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: acts as a mode 3 controller, 8 clk_in per SCLK phase.
module tb_spi_peripheral;
  localparam int SIZE = 40;
  localparam int HP   = 8;

  logic            clk_in = 1'b0;
  logic            reset_n_in;
  logic            sclk_in, cs_n_in, mosi_in;
  logic            miso_out, miso_oe_out;
  logic [SIZE-1:0] tx_data_in;
  logic            tx_load_in;
  logic [SIZE-1:0] rx_data_out;
  logic            rx_valid_out, frame_error_out, busy_out;

  spi_peripheral #(.SIZE(SIZE), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .sclk_in(sclk_in), .cs_n_in(cs_n_in),
    .mosi_in(mosi_in), .miso_out(miso_out), .miso_oe_out(miso_oe_out),
    .tx_data_in(tx_data_in), .tx_load_in(tx_load_in), .rx_data_out(rx_data_out),
    .rx_valid_out(rx_valid_out), .frame_error_out(frame_error_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int          n_chk = 0, n_pass = 0;
  int          pv = 0, pe = 0;
  int          v_lat, e_lat, v_cnt, e_cnt;
  logic        act_seen = 1'b0;
  logic [63:0] miso_cap;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (rx_valid_out)    pv++;
    if (frame_error_out) pe++;
    act_seen = act_seen | busy_out | miso_oe_out;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_tx(input logic [SIZE-1:0] w);
    tx_data_in = w; tx_load_in = 1'b1;
    tick();
    tx_load_in = 1'b0;
  endtask

  task automatic cs_low();
    cs_n_in = 1'b0;
    miso_cap = '0;
    wait_cyc(HP);
  endtask

  // Bit i of the frame carries mosi_w[SIZE-1-i]; bits past SIZE send 0.
  task automatic clk_bits(input int first, input int n, input logic [SIZE-1:0] mosi_w);
    for (int i = first; i < first + n; i++) begin
      sclk_in = 1'b0;
      mosi_in = (i < SIZE) ? mosi_w[SIZE-1-i] : 1'b0;
      wait_cyc(HP);
      miso_cap = {miso_cap[62:0], miso_out};
      sclk_in = 1'b1;
      wait_cyc(HP);
    end
  endtask

  task automatic cs_high_watch();
    int pv0, pe0;
    cs_n_in = 1'b1;
    v_lat = 0; e_lat = 0; pv0 = pv; pe0 = pe;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (rx_valid_out && v_lat == 0)    v_lat = k;
      if (frame_error_out && e_lat == 0) e_lat = k;
    end
    v_cnt = pv - pv0;
    e_cnt = pe - pe0;
    wait_cyc(HP);
  endtask

  task automatic full_frame(input int n, input logic [SIZE-1:0] mosi_w);
    cs_low();
    clk_bits(0, n, mosi_w);
    cs_high_watch();
  endtask

  initial begin
    reset_n_in = 1'b0; sclk_in = 1'b1; cs_n_in = 1'b1; mosi_in = 1'b0;
    tx_data_in = '0; tx_load_in = 1'b0;
    wait_cyc(3);
    chk("reset_outputs", {58'd0, miso_out, miso_oe_out, rx_valid_out,
                          frame_error_out, busy_out, |rx_data_out}, 64'd0);
    reset_n_in = 1'b1;
    wait_cyc(10);

    // Nominal frame
    load_tx(40'hA512345678);
    full_frame(40, 40'h123456789A);
    chk("f1_miso", miso_cap[39:0], 64'hA512345678);
    chk("f1_rx", rx_data_out, 64'h123456789A);
    chk("f1_vcnt", v_cnt, 1);
    chk("f1_vlat", v_lat, 4);
    chk("f1_ecnt", e_cnt, 0);

    // Short frame
    full_frame(39, 40'hFFFF000011);
    chk("short_ecnt", e_cnt, 1);
    chk("short_vcnt", v_cnt, 0);
    chk("short_elat", e_lat, 4);
    chk("short_rx_kept", rx_data_out, 64'h123456789A);

    // Long frame: 41st bit of MISO is 0
    full_frame(41, 40'h00FF00FF00);
    chk("long_ecnt", e_cnt, 1);
    chk("long_vcnt", v_cnt, 0);
    chk("long_rx_kept", rx_data_out, 64'h123456789A);
    chk("long_miso40", miso_cap[40:1], 64'hA512345678);
    chk("long_miso_b41", miso_cap[0], 0);

    // Back-to-back resend, then a load mid-frame only affects the next frame
    full_frame(40, 40'h0102030405);
    chk("b2b_miso", miso_cap[39:0], 64'hA512345678);
    chk("b2b_rx", rx_data_out, 64'h0102030405);
    cs_low();
    load_tx(40'h00000000FF);
    clk_bits(0, 40, 40'h5555AAAA33);
    cs_high_watch();
    chk("midload_f1_miso", miso_cap[39:0], 64'hA512345678);
    chk("midload_f1_rx", rx_data_out, 64'h5555AAAA33);
    full_frame(40, 40'h8000000001);
    chk("midload_f2_miso", miso_cap[39:0], 64'h00000000FF);
    chk("midload_f2_rx", rx_data_out, 64'h8000000001);
    chk("midload_f2_vcnt", v_cnt, 1);

    // Final rising SCLK edge coincides with CS rise: that edge is dropped
    cs_low();
    clk_bits(0, 39, 40'h123456789A);
    sclk_in = 1'b0; mosi_in = 1'b0;
    wait_cyc(HP);
    sclk_in = 1'b1;
    cs_high_watch();
    chk("same_edge_ecnt", e_cnt, 1);
    chk("same_edge_vcnt", v_cnt, 0);

    // Reset mid-frame, release with CS low, finish the frame
    cs_low();
    clk_bits(0, 20, 40'hDEADBEEF12);
    reset_n_in = 1'b0;
    wait_cyc(2);
    chk("midrst_outputs", {58'd0, miso_out, miso_oe_out, rx_valid_out,
                           frame_error_out, busy_out, |rx_data_out}, 64'd0);
    reset_n_in = 1'b1;
    act_seen = 1'b0;
    clk_bits(20, 20, 40'hDEADBEEF12);
    chk("midrst_no_busy", act_seen, 0);
    cs_high_watch();
    chk("midrst_vcnt", v_cnt, 0);
    chk("midrst_ecnt", e_cnt, 0);
    full_frame(40, 40'hCAFEBABE01);
    chk("postrst_rx", rx_data_out, 64'hCAFEBABE01);
    chk("postrst_vcnt", v_cnt, 1);
    chk("postrst_miso", miso_cap[39:0], 64'h0);

    // Idle toggling with CS high
    begin
      int pv0, pe0;
      pv0 = pv; pe0 = pe; act_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        sclk_in = ~sclk_in; mosi_in = ~mosi_in;
        wait_cyc(HP);
      end
      chk("idle_act", act_seen, 0);
      chk("idle_pulses", (pv - pv0) + (pe - pe0), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
